writeback_source_queue: RTL and testbench

WRITEBACK_SOURCE_QUEUE -- requirements
Module: writeback_source_queue

---
 rtl/wb_pkg.sv | 28 ++
 rtl/wb_entry_fifo.sv | 63 ++++++
 rtl/writeback_source_queue.sv | 84 ++++++++
 tb/tb_writeback_source_queue.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared writeback definitions used by the result queues and the writeback mux.
// Entry layout {addr, tag, data}, packed MSB first.
package wb_pkg;

    localparam int WB_DATA_W  = 16;
    localparam int WB_TAG_W   = 6;
    localparam int WB_ADDR_W  = 4;
    localparam int WB_DEPTH   = 4;
    localparam int WB_ENTRY_W = WB_ADDR_W + WB_TAG_W + WB_DATA_W;

    typedef struct packed {
        logic [WB_ADDR_W-1:0] addr;
        logic [WB_TAG_W-1:0]  tag;
        logic [WB_DATA_W-1:0] data;
    } wb_entry_t;

    // Builds an entry in the shared layout from its three fields.
    function automatic wb_entry_t packEntry(input logic [WB_DATA_W-1:0] data,
                                            input logic [WB_TAG_W-1:0]  tag,
                                            input logic [WB_ADDR_W-1:0] addr);
        wb_entry_t e;
        e.addr = addr;
        e.tag  = tag;
        e.data = data;
        return e;
    endfunction

endpackage

// File: rtl/wb_entry_fifo.sv
// Circular entry storage for the writeback source queue.
// Holds pointers and occupancy; the payload array is intentionally not reset.
module wb_entry_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 26
) (
    input  logic                       clk,
    input  logic                       async_rst_n,
    input  logic                       clk_en,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           writeData,
    output logic [WIDTH-1:0]           readData,
    output logic [$clog2(DEPTH):0]     occupancy
);

    localparam int PTRW = $clog2(DEPTH);
    localparam int OCCW = PTRW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTRW-1:0]  wrPtr;
    logic [PTRW-1:0]  rdPtr;
    logic             full;
    logic             empty;
    logic             rdEn;
    logic             wrEn;

    assign full  = (occupancy == OCCW'(DEPTH));
    assign empty = (occupancy == '0);
    assign rdEn  = clk_en && pop && !empty;
    assign wrEn  = clk_en && push && (!full || rdEn);

    assign readData = mem[rdPtr];

    // Payload write; contents survive reset, only the pointers decide validity.
    always_ff @(posedge clk) begin
        if (wrEn) begin
            mem[wrPtr] <= writeData;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            wrPtr     <= '0;
            rdPtr     <= '0;
            occupancy <= '0;
        end else begin
            if (wrEn) begin
                wrPtr <= wrPtr + PTRW'(1);
            end
            if (rdEn) begin
                rdPtr <= rdPtr + PTRW'(1);
            end
            case ({wrEn, rdEn})
                2'b10:   occupancy <= occupancy + OCCW'(1);
                2'b01:   occupancy <= occupancy - OCCW'(1);
                default: occupancy <= occupancy;
            endcase
        end
    end

endmodule

// File: rtl/writeback_source_queue.sv
// Writeback source queue: buffers functional unit results in push order and
// presents the oldest one to the writeback mux with an ACK/REQ handshake.
// Optional feature macro: WB_SOURCE_BYPASS_EN lets an offered result reach the
// mux in the same cycle when the queue is empty.
module writeback_source_queue
    import wb_pkg::*;
#(
    parameter int DATABITWIDTH    = WB_DATA_W,
    parameter int TAGBITWIDTH     = WB_TAG_W,
    parameter int REGADDRBITWIDTH = WB_ADDR_W,
    parameter int DEPTH           = WB_DEPTH
) (
    input  logic                       clk,
    input  logic                       async_rst_n,
    input  logic                       clk_en,
    input  logic                       InValid,
    output logic                       InReady,
    input  logic [DATABITWIDTH-1:0]    InData,
    input  logic [TAGBITWIDTH-1:0]     InTag,
    input  logic [REGADDRBITWIDTH-1:0] InAddr,
    output logic                       WritebackACK,
    input  logic                       WritebackREQ,
    output logic [DATABITWIDTH-1:0]    WritebackData,
    output logic [TAGBITWIDTH-1:0]     WritebackTag,
    output logic [REGADDRBITWIDTH-1:0] WritebackAddr,
    output logic [$clog2(DEPTH):0]     Occupancy
);

    localparam int OCCW   = $clog2(DEPTH) + 1;
    localparam int ENTRYW = REGADDRBITWIDTH + TAGBITWIDTH + DATABITWIDTH;

    logic [ENTRYW-1:0] inEntry;
    logic [ENTRYW-1:0] fifoHead;
    logic [ENTRYW-1:0] headEntry;
    logic [OCCW-1:0]   fifoOccupancy;
    logic              hasEntry;
    logic              bypassActive;
    logic              pop;
    logic              push;
    logic              fifoPush;
    logic              fifoPop;

    // Same field order as wb_entry_t so entries stay interchangeable with the mux side.
    assign inEntry  = {InAddr, InTag, InData};
    assign hasEntry = (fifoOccupancy != '0);

`ifdef WB_SOURCE_BYPASS_EN
    assign bypassActive = !hasEntry && InValid;
`else
    assign bypassActive = 1'b0;
`endif

    // ACK and head data come only from stored state and the offered input, never from REQ.
    assign WritebackACK = hasEntry || bypassActive;
    assign headEntry    = hasEntry ? fifoHead : inEntry;

    assign pop      = WritebackACK && WritebackREQ && clk_en;
    assign InReady  = (fifoOccupancy < OCCW'(DEPTH)) || pop;
    assign push     = InValid && InReady && clk_en;

    // A bypassed result that is consumed immediately never needs a storage slot.
    assign fifoPush = push && !(bypassActive && pop);
    assign fifoPop  = pop && hasEntry;

    assign WritebackAddr = WritebackACK ? headEntry[ENTRYW-1 -: REGADDRBITWIDTH] : '0;
    assign WritebackTag  = WritebackACK ? headEntry[DATABITWIDTH +: TAGBITWIDTH] : '0;
    assign WritebackData = WritebackACK ? headEntry[DATABITWIDTH-1:0]           : '0;
    assign Occupancy     = fifoOccupancy;

    wb_entry_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRYW)
    ) entryFifo (
        .clk         (clk),
        .async_rst_n (async_rst_n),
        .clk_en      (clk_en),
        .push        (fifoPush),
        .pop         (fifoPop),
        .writeData   (inEntry),
        .readData    (fifoHead),
        .occupancy   (fifoOccupancy)
    );

endmodule

// File: tb/tb_writeback_source_queue.sv
// Directed testbench for writeback_source_queue (default parameters).
// Expectations adapt to WB_SOURCE_BYPASS_EN when the build defines it.
module tb_writeback_source_queue;
    import wb_pkg::*;

    logic        clk;
    logic        async_rst_n;
    logic        clk_en;
    logic        InValid;
    logic        InReady;
    logic [15:0] InData;
    logic [5:0]  InTag;
    logic [3:0]  InAddr;
    logic        WritebackACK;
    logic        WritebackREQ;
    logic [15:0] WritebackData;
    logic [5:0]  WritebackTag;
    logic [3:0]  WritebackAddr;
    logic [2:0]  Occupancy;

    int assertCount = 0;
    int failCount   = 0;

    writeback_source_queue dut (
        .clk           (clk),
        .async_rst_n   (async_rst_n),
        .clk_en        (clk_en),
        .InValid       (InValid),
        .InReady       (InReady),
        .InData        (InData),
        .InTag         (InTag),
        .InAddr        (InAddr),
        .WritebackACK  (WritebackACK),
        .WritebackREQ  (WritebackREQ),
        .WritebackData (WritebackData),
        .WritebackTag  (WritebackTag),
        .WritebackAddr (WritebackAddr),
        .Occupancy     (Occupancy)
    );

    // Free-running 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic vld, input logic req, input logic en,
                                 input logic [5:0] tag, input logic [15:0] data, input logic [3:0] addr);
        wb_entry_t e;
        e            = packEntry(data, tag, addr);
        InValid      = vld;
        WritebackREQ = req;
        clk_en       = en;
        InTag        = e.tag;
        InData       = e.data;
        InAddr       = e.addr;
    endtask

    task automatic stepCycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic pushTag(input logic [5:0] tag);
        applyStimulus(1'b1, 1'b0, 1'b1, tag, 16'h1000 + 16'(tag), tag[3:0]);
        stepCycle();
    endtask

    task automatic idle();
        applyStimulus(1'b0, 1'b0, 1'b1, 6'd0, 16'd0, 4'd0);
    endtask

    // Scoreboard state for the randomized-handshake ordering run.
    int q[$];
    int nextTag;
    int popped;
    int curTag;
    logic mAck, mByp, mPop, mReady, mPush, req, en, vld;

    initial begin
        async_rst_n = 1'b0;
        idle();
        #1;
        checkOutput("rstAck", 32'(WritebackACK), 32'd0);
        checkOutput("rstOcc", 32'(Occupancy), 32'd0);
        checkOutput("rstData", 32'(WritebackData), 32'd0);
        @(negedge clk);
        @(negedge clk);
        async_rst_n = 1'b1;
        #1;
        checkOutput("rstReady", 32'(InReady), 32'd1);

        // Single push, held until REQ.
        applyStimulus(1'b1, 1'b0, 1'b1, 6'd5, 16'h1234, 4'd3);
        #1;
`ifdef WB_SOURCE_BYPASS_EN
        checkOutput("singleSameAck", 32'(WritebackACK), 32'd1);
`else
        checkOutput("singleSameAck", 32'(WritebackACK), 32'd0);
        checkOutput("singleSameData", 32'(WritebackData), 32'd0);
`endif
        stepCycle();
        idle();
        #1;
        checkOutput("singleAck", 32'(WritebackACK), 32'd1);
        checkOutput("singleData", 32'(WritebackData), 32'h1234);
        checkOutput("singleTag", 32'(WritebackTag), 32'd5);
        checkOutput("singleAddr", 32'(WritebackAddr), 32'd3);
        checkOutput("singleOcc", 32'(Occupancy), 32'd1);
        stepCycle();
        checkOutput("singleHoldAck", 32'(WritebackACK), 32'd1);
        checkOutput("singleHoldTag", 32'(WritebackTag), 32'd5);
        applyStimulus(1'b0, 1'b1, 1'b1, 6'd0, 16'd0, 4'd0);
        stepCycle();
        idle();
        #1;
        checkOutput("singlePopOcc", 32'(Occupancy), 32'd0);
        checkOutput("singlePopAck", 32'(WritebackACK), 32'd0);
        checkOutput("singlePopData", 32'(WritebackData), 32'd0);

        // Fill to full, refuse a fifth, then simultaneous push and pop.
        for (int i = 0; i < 4; i++) pushTag(6'(11 + i));
        idle();
        #1;
        checkOutput("fullOcc", 32'(Occupancy), 32'd4);
        checkOutput("fullReady", 32'(InReady), 32'd0);
        applyStimulus(1'b1, 1'b0, 1'b1, 6'd15, 16'h100F, 4'd15);
        #1;
        checkOutput("fullRefuseReady", 32'(InReady), 32'd0);
        stepCycle();
        #1;
        checkOutput("fullRefuseOcc", 32'(Occupancy), 32'd4);
        checkOutput("fullRefuseHead", 32'(WritebackTag), 32'd11);
        applyStimulus(1'b1, 1'b1, 1'b1, 6'd15, 16'h100F, 4'd15);
        #1;
        checkOutput("fullSwapReady", 32'(InReady), 32'd1);
        stepCycle();
        idle();
        #1;
        checkOutput("fullSwapOcc", 32'(Occupancy), 32'd4);
        for (int i = 0; i < 4; i++) begin
            checkOutput("fullDrainTag", 32'(WritebackTag), 32'(12 + i));
            checkOutput("fullDrainData", 32'(WritebackData), 32'(16'h1000 + 16'(12 + i)));
            applyStimulus(1'b0, 1'b1, 1'b1, 6'd0, 16'd0, 4'd0);
            stepCycle();
        end
        checkOutput("fullDrainOcc", 32'(Occupancy), 32'd0);

        // clk_en low freezes everything.
        pushTag(6'd20);
        pushTag(6'd21);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 6'd22, 16'h1016, 4'd6);
            stepCycle();
            #1;
            checkOutput("stallOcc", 32'(Occupancy), 32'd2);
            checkOutput("stallTag", 32'(WritebackTag), 32'd20);
        end
        applyStimulus(1'b0, 1'b1, 1'b1, 6'd0, 16'd0, 4'd0);
        stepCycle();
        stepCycle();
        checkOutput("stallDrainOcc", 32'(Occupancy), 32'd0);

        // Asynchronous reset between edges discards stored entries.
        pushTag(6'd30);
        pushTag(6'd31);
        pushTag(6'd32);
        idle();
        #1;
        checkOutput("midRstPreOcc", 32'(Occupancy), 32'd3);
        #1;
        async_rst_n = 1'b0;
        #1;
        checkOutput("midRstAck", 32'(WritebackACK), 32'd0);
        checkOutput("midRstOcc", 32'(Occupancy), 32'd0);
        checkOutput("midRstData", 32'(WritebackData), 32'd0);
        @(negedge clk);
        async_rst_n = 1'b1;
        pushTag(6'd40);
        idle();
        #1;
        checkOutput("postRstAck", 32'(WritebackACK), 32'd1);
        checkOutput("postRstTag", 32'(WritebackTag), 32'd40);
        checkOutput("postRstOcc", 32'(Occupancy), 32'd1);
        applyStimulus(1'b0, 1'b1, 1'b1, 6'd0, 16'd0, 4'd0);
        stepCycle();
        checkOutput("postRstDrainOcc", 32'(Occupancy), 32'd0);

        // Offer into an empty queue with REQ already high.
        applyStimulus(1'b1, 1'b1, 1'b1, 6'd9, 16'h0909, 4'd9);
        #1;
`ifdef WB_SOURCE_BYPASS_EN
        checkOutput("bypassAck", 32'(WritebackACK), 32'd1);
        checkOutput("bypassTag", 32'(WritebackTag), 32'd9);
`else
        checkOutput("bypassAck", 32'(WritebackACK), 32'd0);
        checkOutput("bypassTag", 32'(WritebackTag), 32'd0);
`endif
        stepCycle();
        idle();
        #1;
`ifdef WB_SOURCE_BYPASS_EN
        checkOutput("bypassOcc", 32'(Occupancy), 32'd0);
`else
        checkOutput("bypassOcc", 32'(Occupancy), 32'd1);
        checkOutput("bypassLateTag", 32'(WritebackTag), 32'd9);
`endif
        applyStimulus(1'b0, 1'b1, 1'b1, 6'd0, 16'd0, 4'd0);
        stepCycle();
        checkOutput("bypassDrainOcc", 32'(Occupancy), 32'd0);

        // Tags 1..10 under random REQ and clk_en, checked against a queue model.
        nextTag = 1;
        popped  = 0;
        for (int cyc = 0; cyc < 400 && popped < 10; cyc++) begin
            vld = (nextTag <= 10);
            req = 1'($urandom_range(0, 1));
            en  = ($urandom_range(0, 3) != 0);
            applyStimulus(vld, req, en, 6'(nextTag), 16'h1000 + 16'(nextTag), 4'(nextTag));
            #1;
`ifdef WB_SOURCE_BYPASS_EN
            mByp = (q.size() == 0) && vld;
`else
            mByp = 1'b0;
`endif
            mAck   = (q.size() > 0) || mByp;
            mPop   = mAck && req && en;
            mReady = (q.size() < 4) || mPop;
            mPush  = vld && mReady && en;
            checkOutput("randAck", 32'(WritebackACK), 32'(mAck));
            checkOutput("randReady", 32'(InReady), 32'(mReady));
            curTag = int'(WritebackTag);
            if (mAck) checkOutput("randHeadTag", 32'(curTag), 32'(mByp ? nextTag : q[0]));
            stepCycle();
            if (mPop) begin
                popped++;
                checkOutput("randOrder", 32'(curTag), 32'(popped));
                if (q.size() > 0) void'(q.pop_front());
            end
            if (mPush) begin
                if (!(mByp && mPop)) q.push_back(nextTag);
                nextTag++;
            end
            checkOutput("randOcc", 32'(Occupancy), 32'(q.size()));
        end
        checkOutput("randPoppedCount", 32'(popped), 32'd10);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
